// File: rtl/rf_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rf_pkg: shared sizes and types for the 8x16 register file.  Rev 1.0  |
// +----------------------------------------------------------------------+
package rf_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 8;

  typedef logic [ADDR_W-1:0] rf_addr_t;
  typedef logic [DATA_W-1:0] rf_data_t;

endpackage : rf_pkg
`default_nettype wire

// File: rtl/rf_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rf_reg: one register with async active-low clear and load enable.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rf_reg
  import rf_pkg::*;
#(
  parameter int WIDTH = rf_pkg::DATA_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (en_i) begin
      data_d = d_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;

endmodule : rf_reg
`default_nettype wire

// File: rtl/reg_file_8x16.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reg_file_8x16: 8x16 register file, 1 sync write, 2 comb reads, R0=0. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module reg_file_8x16
  import rf_pkg::*;
#(
  parameter int DATA_W = rf_pkg::DATA_W,
  parameter int ADDR_W = rf_pkg::ADDR_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              WE,
  input  logic [ADDR_W-1:0] WADDR,
  input  logic [DATA_W-1:0] WDATA,
  input  logic [ADDR_W-1:0] RADDR1,
  input  logic [ADDR_W-1:0] RADDR2,
  output logic [DATA_W-1:0] RA_DATA,
  output logic [DATA_W-1:0] RB_DATA
);

  localparam int NREGS = 1 << ADDR_W;

  logic [NREGS-1:1]              wr_en;
  logic [NREGS-1:0][DATA_W-1:0]  rd_vec;

  // Index 0 never gets an enable, so writes to R0 simply vanish.
  always_comb begin
    wr_en = '0;
    for (int i = 1; i < NREGS; i++) begin
      wr_en[i] = WE && (WADDR == ADDR_W'(i));
    end
  end

  assign rd_vec[0] = '0;

  generate
    for (genvar g = 1; g < NREGS; g++) begin : g_regs
      rf_reg #(
        .WIDTH (DATA_W)
      ) u_reg (
        .clk_i  (CLK),
        .rst_ni (RST_N),
        .en_i   (wr_en[g]),
        .d_i    (WDATA),
        .q_o    (rd_vec[g])
      );
    end : g_regs
  endgenerate

  assign RA_DATA = rd_vec[RADDR1];
  assign RB_DATA = rd_vec[RADDR2];

endmodule : reg_file_8x16
`default_nettype wire

// File: tb/tb_reg_file_8x16.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_reg_file_8x16: directed self-checking bench for reg_file_8x16.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_reg_file_8x16;
  import rf_pkg::*;

  logic     clk;
  logic     rst_n;
  logic     we;
  rf_addr_t waddr;
  rf_data_t wdata;
  rf_addr_t raddr1;
  rf_addr_t raddr2;
  rf_data_t ra_data;
  rf_data_t rb_data;

  int checks   = 0;
  int failures = 0;

  reg_file_8x16 #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .CLK     (clk),
    .RST_N   (rst_n),
    .WE      (we),
    .WADDR   (waddr),
    .WDATA   (wdata),
    .RADDR1  (raddr1),
    .RADDR2  (raddr2),
    .RA_DATA (ra_data),
    .RB_DATA (rb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input rf_data_t obs, input rf_data_t exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic write_reg(input rf_addr_t a, input rf_data_t d);
    @(negedge clk);
    we    = 1'b1;
    waddr = a;
    wdata = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic read_pair(input rf_addr_t a1, input rf_addr_t a2);
    raddr1 = a1;
    raddr2 = a2;
    #1;
  endtask

  rf_data_t exp_a;
  rf_data_t exp_b;

  initial begin
    rst_n  = 1'b0;
    we     = 1'b0;
    waddr  = '0;
    wdata  = '0;
    raddr1 = '0;
    raddr2 = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    read_pair(3'd3, 3'd7);
    check("reset_ra_r3", ra_data, 16'h0000);
    check("reset_rb_r7", rb_data, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic write/read
    write_reg(3'd2, 16'h0625);
    write_reg(3'd3, 16'h00CB);
    idle();
    read_pair(3'd2, 3'd3);
    check("basic_ra_r2", ra_data, 16'h0625);
    check("basic_rb_r3", rb_data, 16'h00CB);
    read_pair(3'd0, 3'd6);
    check("basic_ra_r0", ra_data, 16'h0000);
    check("basic_rb_r6", rb_data, 16'h0000);

    // R0 hardwired
    write_reg(3'd0, 16'hFFFF);
    idle();
    read_pair(3'd0, 3'd2);
    check("r0_after_write", ra_data, 16'h0000);
    check("r0_write_no_alias", rb_data, 16'h0625);

    // Write enable low
    @(negedge clk);
    we    = 1'b0;
    waddr = 3'd5;
    wdata = 16'hBEEF;
    repeat (3) @(posedge clk);
    #1;
    read_pair(3'd5, 3'd5);
    check("we0_r5_ra", ra_data, 16'h0000);
    check("we0_r5_rb", rb_data, 16'h0000);

    // Read-during-write
    write_reg(3'd4, 16'h1111);
    @(negedge clk);
    we     = 1'b1;
    waddr  = 3'd4;
    wdata  = 16'h2222;
    raddr1 = 3'd4;
    raddr2 = 3'd4;
    #1;
    check("rdw_before_ra", ra_data, 16'h1111);
    check("rdw_before_rb", rb_data, 16'h1111);
    @(posedge clk);
    #1;
    check("rdw_after_ra", ra_data, 16'h2222);
    check("rdw_after_rb", rb_data, 16'h2222);

    // Back-to-back overwrite of one address
    write_reg(3'd6, 16'hAAAA);
    write_reg(3'd6, 16'h5555);
    idle();
    read_pair(3'd6, 3'd4);
    check("b2b_r6", ra_data, 16'h5555);
    check("b2b_r4_kept", rb_data, 16'h2222);

    // Full sweep over all read-address pairs
    for (int i = 1; i < 8; i++) begin
      write_reg(rf_addr_t'(i), 16'h1000 + rf_data_t'(i));
    end
    idle();
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        read_pair(rf_addr_t'(a), rf_addr_t'(b));
        exp_a = (a == 0) ? 16'h0000 : 16'h1000 + rf_data_t'(a);
        exp_b = (b == 0) ? 16'h0000 : 16'h1000 + rf_data_t'(b);
        check($sformatf("sweep_ra_%0d_%0d", a, b), ra_data, exp_a);
        check($sformatf("sweep_rb_%0d_%0d", a, b), rb_data, exp_b);
      end
    end

    // Asynchronous reset mid-cycle, with a pending write that must be lost
    @(negedge clk);
    we    = 1'b1;
    waddr = 3'd1;
    wdata = 16'h1234;
    #2;
    rst_n = 1'b0;
    #1;
    for (int a = 0; a < 8; a++) begin
      read_pair(rf_addr_t'(a), rf_addr_t'(7 - a));
      check($sformatf("async_rst_ra_%0d", a), ra_data, 16'h0000);
      check($sformatf("async_rst_rb_%0d", a), rb_data, 16'h0000);
    end
    @(posedge clk);
    #1;
    read_pair(3'd1, 3'd7);
    check("rst_write_ignored_r1", ra_data, 16'h0000);
    check("rst_hold_r7", rb_data, 16'h0000);

    // First edge after release performs a write
    @(negedge clk);
    rst_n = 1'b1;
    wdata = 16'h7777;
    @(posedge clk);
    #1;
    read_pair(3'd1, 3'd2);
    check("post_rst_write_r1", ra_data, 16'h7777);
    check("post_rst_r2_cleared", rb_data, 16'h0000);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_reg_file_8x16
`default_nettype wire

// File: doc/reg_file_8x16.md
# reg_file_8x16

Eight-entry, 16-bit general-purpose register file for the 16-bit RISC datapath. It has one synchronous write port and two independent combinational read ports. The read ports feed the ALU A and B operands, and the write port takes the writeback result. Register 0 reads as constant zero.

## Interface
Parameters:
- DATA_W, 16, register width in bits.
- ADDR_W, 3, address width; depth is 2**ADDR_W = 8.

Ports:
- CLK  in  1  system clock; all state updates occur on its rising edge.
- RST_N  in  1  reset, asynchronous and active-low.
- WE  in  1  write enable, sampled on the CLK rising edge.
- WADDR  in  ADDR_W  write register index.
- WDATA  in  DATA_W  write data.
- RADDR1  in  ADDR_W  read port A index.
- RADDR2  in  ADDR_W  read port B index.
- RA_DATA  out  DATA_W  contents of register RADDR1.
- RB_DATA  out  DATA_W  contents of register RADDR2.

One clock; reset is asynchronous and active-low.

## Operation
- Storage: registers R1..R7, each DATA_W bits wide.
- R0 is not stored. It always reads 16'h0000.
- Write: on a CLK rising edge with RST_N=1 and WE=1, R[WADDR] takes WDATA. A write to WADDR=0 is silently discarded.
- WE=0: no register changes. WADDR and WDATA are don't-care.
- Read: RA_DATA = R[RADDR1] and RB_DATA = R[RADDR2]. Both are purely combinational, with no clock or enable.
- Both read ports may address the same register and then return identical data.
- Reset: while RST_N=0, all of R1..R7 are forced to 16'h0000 immediately, independent of CLK.
- Writes are ignored while RST_N=0.
- Outputs with reset asserted: RA_DATA = RB_DATA = 16'h0000 for any address.
- X/unknown read addresses are not qualified. Behaviour follows the simulator's mux semantics.

## Timing
- Write latency: 1 edge. A write is visible on the read ports in the delta after the capturing rising edge.
- Read-during-write to the same register in the same cycle:
  - Before the edge, the read port returns the old value (no write-to-read bypass).
  - After the edge, it returns the new value.
- Read latency: 0 cycles (combinational from RADDRx and the register contents).
- Reset release: the first rising edge with RST_N=1 may perform a write.
  - Deassertion is used directly, with no internal synchronizer.
  - The integrating top level guarantees that RST_N deasserts synchronously to CLK.
- Reset asserted mid-operation: any pending write is lost. Contents return to zero asynchronously.
- Back-to-back writes on consecutive edges to any addresses are each committed. A later write to the same address overwrites an earlier one.

## Structure
- Shared package rf_pkg:
  - constants DATA_W=16, ADDR_W=3, NUM_REGS=8;
  - typedefs rf_addr_t (ADDR_W bits) and rf_data_t (DATA_W bits), reused by the decoder and datapath.
- Natural sub-module rf_reg: one DATA_W register with async active-low clear and a write enable, instantiated 7 times (R1..R7).
- Top level contains:
  - the write-address decoder, which generates the per-register enable WE && (WADDR==i) with i≠0;
  - two 8:1 read muxes, where mux input 0 is tied to zero.

## Test plan
- Reset: assert RST_N=0 at any time after registers hold nonzero data -> every RADDR1/RADDR2 value reads 16'h0000 without waiting for a clock edge.
- Basic write/read:
  - after reset, write 16'h0625 to R2, then 16'h00CB to R3, on successive edges;
  - set WE=0, RADDR1=2, RADDR2=3 -> RA_DATA=16'h0625, RB_DATA=16'h00CB;
  - then RADDR1=0, RADDR2=6 -> both read 16'h0000.
- R0 hardwired: write 16'hFFFF to WADDR=0 with WE=1 -> RADDR1=0 still reads 16'h0000.
- Write enable: WE=0 with WADDR=5, WDATA=16'hBEEF over several edges -> R5 keeps its previous value (16'h0000 after reset).
- Read-during-write: RADDR1=RADDR2=4, R4=16'h1111, WE=1, WADDR=4, WDATA=16'h2222 ->
  - both ports show 16'h1111 before the edge and 16'h2222 after it.
- Full sweep: write 16'h1000+i to each i=1..7 -> read back every pair (RADDR1, RADDR2) over all 64 combinations and match the expected values, with R0=0.
